pmu_sample_drain: RTL and testbench
===================================

Name: pmu_sample_drain

Overview:
- Consumer end of the PMU sampler handshake. Accepts each wide counter snapshot (sample_valid / sample_data / sample_ack) from the counter sampler.
- Serializes the snapshot into one record per counter. Each record holds the raw value or the wrap-safe delta since the previous snapshot.
- Records are buffered in a ring that the host/debug fabric pops one record at a time.
- Snapshots that arrive without room in the ring are dropped and counted, so the sampler never stalls.

Parameters:
- NUM_CNTRS, 8, counters per snapshot; must be >= 2.
- WIDTH, 48, bits per counter field.
- DEPTH, 64, ring entries; power of two and >= NUM_CNTRS.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- sample_valid  in  1  snapshot available; held high by the producer until it sees sample_ack.
- sample_data  in  NUM_CNTRS*WIDTH  snapshot; counter k occupies bits [k*WIDTH +: WIDTH].
- sample_ack  out  1  one-cycle accept/drop pulse.
- delta_mode  in  1  1 = store delta, 0 = store raw value; sampled at capture.
- clear  in  1  synchronous flush.
- rd_en  in  1  pop the head record.
- rd_valid  out  1  ring not empty.
- rd_data  out  WIDTH  head record value.
- rd_idx  out  $clog2(NUM_CNTRS)  counter index of the head record.
- rd_first  out  1  head record is counter 0 of its snapshot.
- fill_level  out  $clog2(DEPTH)+1  occupied entries.
- drop_count  out  16  dropped snapshots; saturates at 16'hFFFF.
- busy  out  1  state != IDLE.

Behaviour:
- Reset (asynchronous, rst=1):
  - state=IDLE; pointers, fill_level and drop_count are 0.
  - sample_ack=0, rd_valid=0, busy=0.
  - prev[] array is 0.
  - Ring contents are don't-care.
- States: IDLE, SER, DROP.
- IDLE, sample_valid=1, with free = DEPTH - fill_level >= NUM_CNTRS:
  - At the clock edge, latch sample_data and delta_mode.
  - Set k=0 and go to SER.
  - sample_ack=1 for exactly the next cycle.
- IDLE, sample_valid=1, with free < NUM_CNTRS:
  - Go to DROP; sample_ack=1 next cycle.
  - drop_count increments, saturating.
  - No ring write; prev[] is unchanged.
- DROP: unconditionally return to IDLE after one cycle. This guarantees the producer has dropped valid before IDLE samples it again.
- SER, each cycle:
  - Write record {idx=k, first=(k==0), val} at wr_ptr and advance wr_ptr.
  - val = delta_mode ? (cur[k] - prev[k]) mod 2^WIDTH : cur[k]. Unsigned subtraction, result truncated to WIDTH, so counter wrap yields the correct delta.
  - prev[k] <= cur[k] in both modes.
  - After k = NUM_CNTRS-1, go to IDLE. SER lasts exactly NUM_CNTRS cycles.
  - Because NUM_CNTRS >= 2, the producer's valid has fallen before IDLE re-samples it.
- The first snapshot after reset or clear yields delta = raw value, since prev=0.
- Space check happens only at capture; SER never overflows because pops only add space.
- Read side (show-ahead):
  - rd_valid = (fill_level != 0).
  - rd_data, rd_idx and rd_first reflect the head entry combinationally from registered storage.
  - rd_en with rd_valid=1 advances rd_ptr at the edge; rd_en while empty is ignored.
- A simultaneous write and pop leaves fill_level unchanged; a write alone adds 1 and a pop alone subtracts 1.
- Pointers carry log2(DEPTH)+1 bits: full when the MSBs differ and the rest are equal. Address wrap is natural modulo DEPTH.
- clear=1 (priority over everything except rst):
  - Next edge empties the ring, zeros prev[] and drop_count, sets state=IDLE, sample_ack=0.
  - An in-progress SER snapshot is abandoned; it was already acked and is not re-requested.
  - sample_valid seen in the same cycle as clear is ignored.
- Asynchronous rst mid-SER aborts immediately, with all state as at reset.

Test Plan:
1. Basic accept: NUM_CNTRS=8, WIDTH=48, DEPTH=16, delta_mode=0, sample_data counter k = k*10+5, valid held until ack.
   - sample_ack is a single pulse one cycle after valid.
   - busy high for 8 cycles.
   - Pops return idx 0..7, values 5,15,…,75; rd_first only on idx 0.
2. Delta with wrap: delta_mode=1.
   - Snapshot A has counter 3 = 2^48-4; snapshot B has counter 3 = 6.
   - Counter 3 record for B = 10; for A = 2^48-4.
3. Drop: no pops, two snapshots fill 16 entries, third snapshot offered.
   - Ack still pulses; drop_count=1; fill_level stays 16; prev[] unchanged.
   - So after popping 8 entries and offering a fourth snapshot, its deltas are relative to the second snapshot.
4. Concurrent pop/write: rd_en held high during SER with fill_level=5 at start.
   - fill_level stays 5 throughout; final read order preserved across the pointer wrap at entry 15→0.
5. clear mid-SER: assert clear at k=3.
   - Next cycle fill_level=0, rd_valid=0, busy=0, drop_count=0.
   - Next snapshot in delta mode returns raw values.
6. Async rst asserted mid-SER between clock edges: outputs go to reset values immediately, before the next edge; the subsequent snapshot is accepted normally.

Source files
------------

// File: rtl/pmu_sample_drain.sv
// ============================================================================
// Module   : pmu_sample_drain
// Purpose  : Accepts PMU counter snapshots, serializes them into per-counter
//            raw/delta records and buffers them in a show-ahead ring.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pmu_sample_drain #(
    parameter int NUM_CNTRS = 8,
    parameter int WIDTH     = 48,
    parameter int DEPTH     = 64
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          sample_valid,
    input  logic [NUM_CNTRS*WIDTH-1:0]    sample_data,
    output logic                          sample_ack,
    input  logic                          delta_mode,
    input  logic                          clear,
    input  logic                          rd_en,
    output logic                          rd_valid,
    output logic [WIDTH-1:0]              rd_data,
    output logic [$clog2(NUM_CNTRS)-1:0]  rd_idx,
    output logic                          rd_first,
    output logic [$clog2(DEPTH):0]        fill_level,
    output logic [15:0]                   drop_count,
    output logic                          busy
);

    localparam int c_kw = $clog2(NUM_CNTRS);
    localparam int c_aw = $clog2(DEPTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SER  = 2'd1,
        DROP = 2'd2
    } state_t;

    state_t             r_state;
    logic               r_ack;
    logic               r_mode;
    logic [c_kw-1:0]    r_k;
    logic [c_aw:0]      r_wr_ptr;
    logic [c_aw:0]      r_rd_ptr;
    logic [15:0]        r_drop;
    logic [WIDTH-1:0]   r_cur   [NUM_CNTRS];
    logic [WIDTH-1:0]   r_prev  [NUM_CNTRS];
    logic [WIDTH-1:0]   r_mem_val   [DEPTH];
    logic [c_kw-1:0]    r_mem_idx   [DEPTH];
    logic               r_mem_first [DEPTH];

    logic [c_aw:0]      w_fill;
    logic               w_room;
    logic               w_pop;
    logic               w_capture;
    logic [WIDTH-1:0]   w_val;

    assign w_fill    = r_wr_ptr - r_rd_ptr;
    assign w_room    = (w_fill <= (c_aw+1)'(DEPTH - NUM_CNTRS));
    assign w_pop     = rd_en && (w_fill != '0);
    assign w_capture = (r_state == IDLE) && sample_valid && !clear && w_room;
    // Unsigned modulo subtraction keeps the delta correct across counter wrap.
    assign w_val     = r_mode ? (r_cur[r_k] - r_prev[r_k]) : r_cur[r_k];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= IDLE;
            r_ack    <= 1'b0;
            r_mode   <= 1'b0;
            r_k      <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_drop   <= '0;
            for (int i = 0; i < NUM_CNTRS; i++) r_prev[i] <= '0;
        end else if (clear) begin
            r_state  <= IDLE;
            r_ack    <= 1'b0;
            r_k      <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_drop   <= '0;
            for (int i = 0; i < NUM_CNTRS; i++) r_prev[i] <= '0;
        end else begin
            r_ack <= 1'b0;
            if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
            case (r_state)
                IDLE: begin
                    if (sample_valid) begin
                        r_ack <= 1'b1;
                        if (w_room) begin
                            r_mode  <= delta_mode;
                            r_k     <= '0;
                            r_state <= SER;
                        end else begin
                            r_state <= DROP;
                            if (r_drop != 16'hFFFF) r_drop <= r_drop + 16'd1;
                        end
                    end
                end
                SER: begin
                    r_wr_ptr   <= r_wr_ptr + 1'b1;
                    r_prev[r_k] <= r_cur[r_k];
                    r_k        <= r_k + 1'b1;
                    if (r_k == c_kw'(NUM_CNTRS - 1)) r_state <= IDLE;
                end
                DROP:    r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    // Snapshot latch and ring storage carry no reset; their contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (w_capture) begin
            for (int i = 0; i < NUM_CNTRS; i++) r_cur[i] <= sample_data[i*WIDTH +: WIDTH];
        end
        if (r_state == SER) begin
            r_mem_val[r_wr_ptr[c_aw-1:0]]   <= w_val;
            r_mem_idx[r_wr_ptr[c_aw-1:0]]   <= r_k;
            r_mem_first[r_wr_ptr[c_aw-1:0]] <= (r_k == '0);
        end
    end

    assign sample_ack = r_ack;
    assign rd_valid   = (w_fill != '0);
    assign rd_data    = r_mem_val[r_rd_ptr[c_aw-1:0]];
    assign rd_idx     = r_mem_idx[r_rd_ptr[c_aw-1:0]];
    assign rd_first   = r_mem_first[r_rd_ptr[c_aw-1:0]];
    assign fill_level = w_fill;
    assign drop_count = r_drop;
    assign busy       = (r_state != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_pmu_sample_drain.sv
// ============================================================================
// Module   : tb_pmu_sample_drain
// Purpose  : Scoreboard bench for pmu_sample_drain (8 counters, 48 bits, 16-entry ring).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pmu_sample_drain;

    localparam int N = 8;
    localparam int W = 48;
    localparam int D = 16;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           sample_valid = 1'b0;
    logic [N*W-1:0] sample_data = '0;
    logic           sample_ack;
    logic           delta_mode = 1'b0;
    logic           clear = 1'b0;
    logic           rd_en = 1'b0;
    logic           rd_valid;
    logic [W-1:0]   rd_data;
    logic [2:0]     rd_idx;
    logic           rd_first;
    logic [4:0]     fill_level;
    logic [15:0]    drop_count;
    logic           busy;

    pmu_sample_drain #(.NUM_CNTRS(N), .WIDTH(W), .DEPTH(D)) dut (
        .clk(clk), .rst(rst),
        .sample_valid(sample_valid), .sample_data(sample_data), .sample_ack(sample_ack),
        .delta_mode(delta_mode), .clear(clear), .rd_en(rd_en),
        .rd_valid(rd_valid), .rd_data(rd_data), .rd_idx(rd_idx), .rd_first(rd_first),
        .fill_level(fill_level), .drop_count(drop_count), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]   idx;
        logic         first;
        logic [W-1:0] val;
    } rec_t;

    rec_t         exp_q [$];
    rec_t         mon_r;
    logic [W-1:0] sv     [N];
    logic [W-1:0] m_prev [N];
    int           n_tests = 0;
    int           n_fail  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: raw value or modulo-2^W difference from the last accepted snapshot.
    task automatic model_push(input logic mode);
        rec_t r;
        for (int k = 0; k < N; k++) begin
            r.idx   = 3'(k);
            r.first = (k == 0);
            r.val   = mode ? (sv[k] - m_prev[k]) : sv[k];
            exp_q.push_back(r);
            m_prev[k] = sv[k];
        end
    endtask

    task automatic model_flush();
        exp_q.delete();
        for (int k = 0; k < N; k++) m_prev[k] = '0;
    endtask

    task automatic set_vals(input logic [W-1:0] base, input logic [W-1:0] step);
        for (int k = 0; k < N; k++) sv[k] = base + W'(k) * step;
    endtask

    task automatic drive_snap(input logic mode);
        for (int k = 0; k < N; k++) sample_data[k*W +: W] = sv[k];
        delta_mode   = mode;
        sample_valid = 1'b1;
    endtask

    // Monitor: every accepted pop is checked against the scoreboard head.
    always @(negedge clk) begin
        if (!rst && rd_en && rd_valid) begin
            if (exp_q.size() == 0) begin
                chk("pop_unexpected", 64'd1, 64'd0);
            end else begin
                mon_r = exp_q.pop_front();
                chk("rd_idx",   64'(rd_idx),   64'(mon_r.idx));
                chk("rd_first", 64'(rd_first), 64'(mon_r.first));
                chk("rd_data",  64'(rd_data),  64'(mon_r.val));
            end
        end
    end

    task automatic offer(input logic mode, input bit exp_drop);
        int lat;
        int bcnt;
        bit got;
        @(posedge clk); #1;
        drive_snap(mode);
        if (!exp_drop) model_push(mode);
        got = 0; lat = 0; bcnt = 0;
        for (int i = 0; i < 10 && !got; i++) begin
            @(negedge clk);
            if (sample_ack) begin
                got = 1; lat = i;
                if (busy) bcnt++;
            end
        end
        chk("ack_seen", 64'(got), 64'd1);
        chk("ack_latency", 64'(lat), 64'd1);
        @(posedge clk); #1;
        sample_valid = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (i == 0) chk("ack_single", 64'(sample_ack), 64'd0);
            if (busy) bcnt++;
            else break;
        end
        chk("busy_cycles", 64'(bcnt), exp_drop ? 64'd1 : 64'(N));
    endtask

    task automatic pop_n(input int n);
        @(posedge clk); #1;
        rd_en = 1'b1;
        repeat (n) @(posedge clk);
        #1;
        rd_en = 1'b0;
    endtask

    task automatic do_clear();
        @(posedge clk); #1;
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        model_flush();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int k = 0; k < N; k++) m_prev[k] = '0;
        repeat (3) @(posedge clk);
        @(negedge clk); rst = 1'b0;
        @(negedge clk);
        chk("rst_ack",   64'(sample_ack), 64'd0);
        chk("rst_valid", 64'(rd_valid),   64'd0);
        chk("rst_busy",  64'(busy),       64'd0);
        chk("rst_fill",  64'(fill_level), 64'd0);
        chk("rst_drop",  64'(drop_count), 64'd0);

        // 1: raw capture k*10+5
        set_vals(48'd5, 48'd10);
        offer(1'b0, 0);
        chk("t1_fill", 64'(fill_level), 64'd8);
        pop_n(8);
        @(negedge clk);
        chk("t1_empty", 64'(rd_valid), 64'd0);

        // 2: delta with counter wrap on counter 3
        do_clear();
        set_vals(48'd0, 48'd1000);
        sv[3] = 48'hFFFF_FFFF_FFFC;
        offer(1'b1, 0);
        set_vals(48'd1, 48'd1001);
        sv[3] = 48'd6;
        offer(1'b1, 0);
        pop_n(3);
        @(negedge clk);
        chk("t2_a3_idx", 64'(rd_idx),  64'd3);
        chk("t2_a3_val", 64'(rd_data), 64'hFFFF_FFFF_FFFC);
        pop_n(8);
        @(negedge clk);
        chk("t2_b3_idx", 64'(rd_idx),  64'd3);
        chk("t2_b3_val", 64'(rd_data), 64'd10);
        pop_n(5);

        // 3: drop when ring is full
        do_clear();
        set_vals(48'd100, 48'd1);
        offer(1'b1, 0);
        set_vals(48'd200, 48'd3);
        offer(1'b1, 0);
        chk("t3_full", 64'(fill_level), 64'd16);
        set_vals(48'd999, 48'd11);
        offer(1'b1, 1);
        chk("t3_drop_cnt", 64'(drop_count), 64'd1);
        chk("t3_fill",     64'(fill_level), 64'd16);
        pop_n(8);
        set_vals(48'd300, 48'd7);
        offer(1'b1, 0);
        pop_n(16);
        @(negedge clk);
        chk("t3_empty", 64'(fill_level), 64'd0);

        // 4: pops concurrent with serialization, read pointer wraps 15->0
        set_vals(48'd50, 48'd2);
        offer(1'b0, 0);
        pop_n(3);
        @(negedge clk);
        chk("t4_fill_start", 64'(fill_level), 64'd5);
        set_vals(48'h1234_0000, 48'd1);
        @(posedge clk); #1;
        drive_snap(1'b0);
        model_push(1'b0);
        @(posedge clk); #1;
        chk("t4_ack", 64'(sample_ack), 64'd1);
        sample_valid = 1'b0;
        rd_en = 1'b1;
        for (int i = 0; i < N; i++) begin
            @(negedge clk);
            chk("t4_fill_const", 64'(fill_level), 64'd5);
        end
        @(posedge clk); #1;
        rd_en = 1'b0;
        @(negedge clk);
        chk("t4_fill_end", 64'(fill_level), 64'd5);
        chk("t4_idle",     64'(busy),       64'd0);
        pop_n(5);

        // 5: clear while serializing counter 3
        set_vals(48'd4000, 48'd5);
        @(posedge clk); #1;
        drive_snap(1'b1);
        model_push(1'b1);
        @(posedge clk); #1;
        sample_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("t5_fill_k3", 64'(fill_level), 64'd3);
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        model_flush();
        @(negedge clk);
        chk("t5_fill",  64'(fill_level), 64'd0);
        chk("t5_valid", 64'(rd_valid),   64'd0);
        chk("t5_busy",  64'(busy),       64'd0);
        chk("t5_drop",  64'(drop_count), 64'd0);
        set_vals(48'd777, 48'd9);
        offer(1'b1, 0);
        pop_n(8);

        // 6: asynchronous reset mid-serialization
        set_vals(48'd60, 48'd4);
        @(posedge clk); #1;
        drive_snap(1'b1);
        model_push(1'b1);
        @(posedge clk); #1;
        sample_valid = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        chk("t6_fill_pre", 64'(fill_level), 64'd2);
        #1;
        rst = 1'b1;
        #1;
        chk("t6_busy",  64'(busy),       64'd0);
        chk("t6_fill",  64'(fill_level), 64'd0);
        chk("t6_valid", 64'(rd_valid),   64'd0);
        chk("t6_ack",   64'(sample_ack), 64'd0);
        model_flush();
        @(negedge clk); rst = 1'b0;
        set_vals(48'h8000_0000_0000, 48'd3);
        offer(1'b1, 0);
        pop_n(8);

        @(negedge clk);
        chk("final_queue", 64'(exp_q.size()), 64'd0);
        chk("final_empty", 64'(rd_valid),     64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
